// File: rtl/mode_sequencer.sv
// Bathroom-controller mode sequencer: one-hot mode select, per-mode timed standby, panel light bus.
// Optional idle auto-stop in ACTIVE is compiled in with `define MODE_SEQ_AUTO_OFF_EN.
module mode_sequencer #(
  parameter int NUM_MODES      = 4,
  parameter int CNT_W          = 4,
  parameter int LIGHT_W        = 16,
  parameter int LAMP_BIT       = 6,
  parameter int AUTO_OFF_TICKS = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       enable,
  input  logic [NUM_MODES-1:0]       btn,
  input  logic                       lamp_btn,
  input  logic                       running,
  input  logic                       startor,
  input  logic [NUM_MODES*CNT_W-1:0] hold_cfg,
  output logic [NUM_MODES-1:0]       mode,
  output logic [LIGHT_W-1:0]         light,
  output logic                       normal,
  output logic [CNT_W-1:0]           remaining,
  output logic                       stop_pulse
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, STOP} state_t;

  state_t               state;
  logic [NUM_MODES-1:0] btn_prev;
  logic                 lamp_prev;
  logic                 press;
  logic                 same_mode;
  logic                 lamp_evt;
  logic                 idle_expire;
  logic [CNT_W-1:0]     press_hold;

  // Only a single fresh button counts; chords and held buttons are ignored.
  assign press     = (btn != '0) && ((btn & (btn - NUM_MODES'(1))) == '0) && (btn_prev == '0);
  assign same_mode = (btn == mode);
  assign lamp_evt  = lamp_btn & ~lamp_prev;

  always_comb begin
    press_hold = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (btn[i]) press_hold = press_hold | hold_cfg[i*CNT_W +: CNT_W];
    end
  end

`ifdef MODE_SEQ_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(AUTO_OFF_TICKS + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign idle_expire = tick && (idle_cnt == IDLE_W'(AUTO_OFF_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!enable || (state != ACTIVE) || press || idle_expire) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign idle_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= '0;
      remaining  <= '0;
      normal     <= 1'b0;
      stop_pulse <= 1'b0;
      light      <= '0;
      btn_prev   <= '0;
      lamp_prev  <= 1'b0;
    end else begin
      btn_prev   <= btn;
      lamp_prev  <= lamp_btn;
      stop_pulse <= 1'b0;

      if (!enable) begin
        state     <= IDLE;
        mode      <= '0;
        remaining <= '0;
        normal    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              state <= ACTIVE;
              mode  <= btn;
            end
          end
          ACTIVE: begin
            if (press && !same_mode) begin
              mode <= btn;
            end else if (press && (press_hold != '0)) begin
              state     <= HOLD;
              remaining <= press_hold;
              normal    <= 1'b1;
            end else if (press || idle_expire) begin
              state      <= STOP;
              mode       <= '0;
              remaining  <= '0;
              normal     <= 1'b0;
              stop_pulse <= 1'b1;
            end
          end
          HOLD: begin
            // A press in the same cycle as a tick takes precedence.
            if (press && !same_mode) begin
              state     <= ACTIVE;
              mode      <= btn;
              remaining <= '0;
              normal    <= 1'b0;
            end else if (press || (tick && (remaining == '0))) begin
              state      <= STOP;
              mode       <= '0;
              remaining  <= '0;
              normal     <= 1'b0;
              stop_pulse <= 1'b1;
            end else if (tick) begin
              remaining <= remaining - CNT_W'(1);
              normal    <= (remaining != CNT_W'(1));
            end
          end
          STOP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end

      if (lamp_evt) begin
        light[LAMP_BIT] <= ~light[LAMP_BIT];
      end else if (running) begin
        light <= {LIGHT_W{startor}};
      end else if (!enable) begin
        light <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed self-checking bench for mode_sequencer using immediate assertions.
module tb_mode_sequencer;

  localparam int NUM_MODES      = 4;
  localparam int CNT_W          = 4;
  localparam int LIGHT_W        = 16;
  localparam int LAMP_BIT       = 6;
  localparam int AUTO_OFF_TICKS = 15;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 tick;
  logic                 enable;
  logic [NUM_MODES-1:0] btn;
  logic                 lamp_btn;
  logic                 running;
  logic                 startor;
  logic [15:0]          hold_cfg;
  logic [NUM_MODES-1:0] mode;
  logic [LIGHT_W-1:0]   light;
  logic                 normal;
  logic [CNT_W-1:0]     remaining;
  logic                 stop_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mode_sequencer #(
    .NUM_MODES(NUM_MODES),
    .CNT_W(CNT_W),
    .LIGHT_W(LIGHT_W),
    .LAMP_BIT(LAMP_BIT),
    .AUTO_OFF_TICKS(AUTO_OFF_TICKS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .enable(enable),
    .btn(btn),
    .lamp_btn(lamp_btn),
    .running(running),
    .startor(startor),
    .hold_cfg(hold_cfg),
    .mode(mode),
    .light(light),
    .normal(normal),
    .remaining(remaining),
    .stop_pulse(stop_pulse)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NUM_MODES-1:0] b, input logic t);
    btn  = b;
    tick = t;
    step(1);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    enable   = 1'b1;
    btn      = '0;
    lamp_btn = 1'b0;
    running  = 1'b0;
    startor  = 1'b0;
    hold_cfg = 16'h0532;  // mode0=2, mode1=3, mode2=5, mode3=0
    #12;
    check_output("rst_mode",   32'(mode), 32'h0);
    check_output("rst_light",  32'(light), 32'h0);
    check_output("rst_normal", 32'(normal), 32'h0);
    check_output("rst_rem",    32'(remaining), 32'h0);
    check_output("rst_stop",   32'(stop_pulse), 32'h0);
    rst_n = 1'b1;
    step(2);

    $display("[TB] press and hold mode 1");
    apply_stimulus(4'b0010, 1'b0);
    check_output("press_m1", 32'(mode), 32'h2);
    repeat (10) apply_stimulus(4'b0010, 1'b0);
    check_output("held_mode", 32'(mode), 32'h2);
    check_output("held_rem", 32'(remaining), 32'h0);
    check_output("held_normal", 32'(normal), 32'h0);
    apply_stimulus(4'b0000, 1'b0);

    $display("[TB] hold countdown on mode 1");
    apply_stimulus(4'b0010, 1'b0);
    check_output("hold_rem3", 32'(remaining), 32'h3);
    check_output("hold_norm3", 32'(normal), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b1);
    check_output("hold_rem2", 32'(remaining), 32'h2);
    apply_stimulus(4'b0000, 1'b1);
    check_output("hold_rem1", 32'(remaining), 32'h1);
    check_output("hold_norm1", 32'(normal), 32'h1);
    apply_stimulus(4'b0000, 1'b1);
    check_output("hold_rem0", 32'(remaining), 32'h0);
    check_output("hold_norm0", 32'(normal), 32'h0);
    check_output("hold_nostop", 32'(stop_pulse), 32'h0);
    check_output("hold_mode", 32'(mode), 32'h2);
    apply_stimulus(4'b0000, 1'b1);
    check_output("expire_stop", 32'(stop_pulse), 32'h1);
    check_output("expire_mode", 32'(mode), 32'h0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("stop_ignores_press", 32'(mode), 32'h0);
    check_output("stop_one_cycle", 32'(stop_pulse), 32'h0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("idle_held_btn", 32'(mode), 32'h0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("idle_press_m0", 32'(mode), 32'h1);

    $display("[TB] zero hold on mode 3 and chords");
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b1000, 1'b0);
    check_output("switch_m3", 32'(mode), 32'h8);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b1000, 1'b0);
    check_output("zero_hold_stop", 32'(stop_pulse), 32'h1);
    check_output("zero_hold_mode", 32'(mode), 32'h0);
    check_output("zero_hold_norm", 32'(normal), 32'h0);
    apply_stimulus(4'b0000, 1'b0);
    check_output("zero_hold_stop_end", 32'(stop_pulse), 32'h0);
    apply_stimulus(4'b0011, 1'b0);
    check_output("multi_hot", 32'(mode), 32'h0);

    $display("[TB] abort hold with other mode plus tick");
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0010, 1'b0);
    check_output("hold2_rem3", 32'(remaining), 32'h3);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b1);
    check_output("hold2_rem2", 32'(remaining), 32'h2);
    apply_stimulus(4'b0100, 1'b1);
    check_output("abort_mode", 32'(mode), 32'h4);
    check_output("abort_rem", 32'(remaining), 32'h0);
    check_output("abort_norm", 32'(normal), 32'h0);
    check_output("abort_nostop", 32'(stop_pulse), 32'h0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0100, 1'b0);
    check_output("hold_m2_rem5", 32'(remaining), 32'h5);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0100, 1'b1);
    check_output("same_press_stop", 32'(stop_pulse), 32'h1);
    check_output("same_press_rem", 32'(remaining), 32'h0);
    apply_stimulus(4'b0000, 1'b0);

    $display("[TB] light bus");
    running = 1'b1; startor = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    check_output("anim_on", 32'(light), 32'hFFFF);
    startor = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    check_output("anim_off", 32'(light), 32'h0000);
    startor = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    running = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    check_output("light_hold", 32'(light), 32'hFFFF);
    lamp_btn = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    check_output("lamp_toggle", 32'(light), 32'hFFBF);
    apply_stimulus(4'b0000, 1'b0);
    check_output("lamp_held", 32'(light), 32'hFFBF);
    lamp_btn = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    lamp_btn = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    check_output("lamp_toggle_back", 32'(light), 32'hFFFF);
    lamp_btn = 1'b0; running = 1'b1; startor = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    lamp_btn = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    check_output("lamp_over_anim", 32'(light), 32'h0040);
    lamp_btn = 1'b0; running = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    check_output("lamp_kept", 32'(light), 32'h0040);

    $display("[TB] enable low");
    apply_stimulus(4'b0001, 1'b0);
    check_output("en_press", 32'(mode), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    enable = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    check_output("en_low_mode", 32'(mode), 32'h0);
    check_output("en_low_light", 32'(light), 32'h0);
    check_output("en_low_nostop", 32'(stop_pulse), 32'h0);
    enable = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("en_hold_rem2", 32'(remaining), 32'h2);
    apply_stimulus(4'b0000, 1'b0);
    enable = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    check_output("en_hold_rem", 32'(remaining), 32'h0);
    check_output("en_hold_norm", 32'(normal), 32'h0);
    check_output("en_hold_nostop", 32'(stop_pulse), 32'h0);
    apply_stimulus(4'b0010, 1'b0);
    check_output("en_low_press", 32'(mode), 32'h0);
    enable = 1'b1;
    apply_stimulus(4'b0000, 1'b0);

    $display("[TB] async reset mid-hold");
    apply_stimulus(4'b0001, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("rst_hold_rem2", 32'(remaining), 32'h2);
    apply_stimulus(4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rem", 32'(remaining), 32'h0);
    check_output("async_norm", 32'(normal), 32'h0);
    check_output("async_mode", 32'(mode), 32'h0);
    rst_n = 1'b1;
    step(1);

`ifdef MODE_SEQ_AUTO_OFF_EN
    $display("[TB] auto-off");
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    repeat (AUTO_OFF_TICKS - 1) apply_stimulus(4'b0000, 1'b1);
    check_output("auto_before", 32'(stop_pulse), 32'h0);
    check_output("auto_before_mode", 32'(mode), 32'h2);
    apply_stimulus(4'b0000, 1'b1);
    check_output("auto_stop", 32'(stop_pulse), 32'h1);
    check_output("auto_stop_mode", 32'(mode), 32'h0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    repeat (AUTO_OFF_TICKS - 2) apply_stimulus(4'b0000, 1'b1);
    apply_stimulus(4'b0100, 1'b1);
    check_output("auto_restart_mode", 32'(mode), 32'h4);
    repeat (AUTO_OFF_TICKS - 1) apply_stimulus(4'b0000, 1'b1);
    check_output("auto_restart_nostop", 32'(stop_pulse), 32'h0);
    check_output("auto_restart_kept", 32'(mode), 32'h4);
    apply_stimulus(4'b0000, 1'b1);
    check_output("auto_restart_stop", 32'(stop_pulse), 32'h1);
`else
    $display("[TB] no auto-off");
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    repeat (AUTO_OFF_TICKS + 5) apply_stimulus(4'b0000, 1'b1);
    check_output("no_auto_mode", 32'(mode), 32'h2);
    check_output("no_auto_stop", 32'(stop_pulse), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
